// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_port_arbiter_if
//  Description : Bundle of the two requester ports and the SDRAM controller
//                port seen by the two-master SDRAM port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_port_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16
) ();
    // Master 0 requester port
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;
    // Master 1 requester port
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;
    // SDRAM controller port
    logic          mem_wr_req;
    logic          mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr_ack;
    logic          mem_rd_ack;
    logic [DW-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output mem_wr_req, mem_rd_req, mem_addr, mem_wdata,
        input  mem_wr_ack, mem_rd_ack, mem_rdata
    );

    // Environment view (requesters plus controller)
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_wr_req, mem_rd_req, mem_addr, mem_wdata,
        output mem_wr_ack, mem_rd_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Two-requester round-robin arbiter sharing one single-word
//                SDRAM controller port. One transaction at a time, read data
//                returned to the winner, hung transactions aborted by timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic            sys_clk,
    input  wire logic            sys_rst,
    sdram_port_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 grant
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          win;
    logic          match;

    // Winner on a tie is the master that did not win last time
    assign win   = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
    // Only the ack type matching the issued request completes it
    assign match = we_q ? bus.mem_wr_ack : bus.mem_rd_ack;

    // Next-state and datapath update for the transaction FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant_d = win;
                    we_d    = win ? bus.m1_we    : bus.m0_we;
                    addr_d  = win ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (match) begin
                    // A real ack beats a simultaneous expiry
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = bus.mem_rdata;
                        end else begin
                            rdata0_d = bus.mem_rdata;
                        end
                    end
                end else if (cnt_q == C_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs decoded from registered state only
    assign bus.mem_wr_req = (state_q == S_WAIT) &&  we_q;
    assign bus.mem_rd_req = (state_q == S_WAIT) && !we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.m0_ack     = (state_q == S_DONE) && !grant_q;
    assign bus.m1_ack     = (state_q == S_DONE) &&  grant_q;
    assign bus.m0_err     = (state_q == S_DONE) && !grant_q && err_q;
    assign bus.m1_err     = (state_q == S_DONE) &&  grant_q && err_q;
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m1_rdata   = rdata1_q;
    assign busy           = (state_q != S_IDLE);
    assign grant          = grant_q;

endmodule
`default_nettype wire
